aes_key_expand: RTL and testbench

Iterative AES-128 key schedule that generates all 11 round keys from a 128-bit cipher key. It sits directly upstream of the round-key adder and supplies its `key` operand. The block computes one round key per clock, stores all eleven in an internal key file, and serves any of them on a registered read port selected by round number. Byte ordering matches the datapath state: byte i occupies bits [i*8 +: 8].

---
 rtl/aes_pkg.sv | 32 +++
 rtl/aes_sbox.sv | 35 +++
 rtl/aes_key_expand.sv | 106 ++++++++++
 tb/tb_aes_key_expand.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, byte/word/block types and GF(2^8) helpers
// used by both the key schedule and the round datapath (SubBytes, MixColumns).
package aes_pkg;

    localparam int AES_NK = 4;
    localparam int AES_NR = 10;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    localparam aes_byte_t RCON_INIT = 8'h01;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic aes_byte_t xtime(input aes_byte_t r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product built from repeated xtime.
    function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t acc;
        aes_byte_t aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8)
// (computed as x^254, with 0 mapping to 0) followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] sub
);

    aes_byte_t inv;

    // x^254 = x^2 * x^4 * ... * x^128, built by repeated squaring.
    function automatic aes_byte_t gf_inv(input aes_byte_t x);
        aes_byte_t pw;
        aes_byte_t acc;
        pw  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            pw  = gf_mul(pw, pw);
            acc = gf_mul(acc, pw);
        end
        return acc;
    endfunction

    assign inv = gf_inv(data);

    // Affine map: XOR of the byte with its left rotations by 1..4, plus 0x63.
    assign sub = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry
// key file, with a registered read port selected by round number.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int word_size  = 8,
    parameter int array_size = 16,
    parameter int num_rounds = AES_NR
)
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [word_size*array_size-1:0] key_in,
    input  logic [3:0]                      round_sel,
    output logic [word_size*array_size-1:0] round_key,
    output logic                            busy,
    output logic                            done
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_t;

    ks_state_t  state;
    aes_block_t rk [num_rounds+1];
    logic [3:0] cnt;
    aes_byte_t  rcon;

    logic [3:0] prev_idx;
    aes_block_t prev_key;
    aes_word_t  w0, w1, w2, w3;
    aes_word_t  rot, subw, t;
    aes_word_t  n0, n1, n2, n3;
    aes_block_t next_key;

    // Previous round key; index wraps to 15 while idle, which reads as zero.
    assign prev_idx = cnt - 4'd1;
    assign prev_key = (prev_idx <= 4'(num_rounds)) ? rk[prev_idx] : '0;

    assign w0 = prev_key[31:0];
    assign w1 = prev_key[63:32];
    assign w2 = prev_key[95:64];
    assign w3 = prev_key[127:96];

    // RotWord moves byte 0 to the top lane: (b0,b1,b2,b3) -> (b1,b2,b3,b0).
    assign rot = {w3[7:0], w3[31:8]};

    for (genvar g = 0; g < AES_NK; g++) begin : g_subword
        aes_sbox u_sbox (
            .data (rot[g*8 +: 8]),
            .sub  (subw[g*8 +: 8])
        );
    end

    assign t  = subw ^ {24'h0, rcon};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n3, n2, n1, n0};

    // Control FSM: accepts start when not busy, writes one key per edge, then holds done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= 4'd0;
            rcon  <= 8'h00;
            for (int i = 0; i <= num_rounds; i++) rk[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rk[0] <= key_in;
                        rcon  <= RCON_INIT;
                        cnt   <= 4'd1;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= EXPAND;
                    end
                end
                EXPAND: begin
                    rk[cnt] <= next_key;
                    rcon    <= xtime(rcon);
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'(num_rounds)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered read port; out-of-range selections return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_key <= '0;
        end else begin
            round_key <= (round_sel <= 4'(num_rounds)) ? rk[round_sel] : '0;
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 and all-zero vectors,
// random keys against a byte-oriented key-schedule model, start re-pulses,
// reset abort, out-of-range reads and restart from DONE.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [3:0]   round_sel;
    logic [127:0] round_key;
    logic         busy;
    logic         done;

    int checksPassed = 0;
    int checksTotal  = 0;

    logic [127:0] modelKeys [11];
    logic [7:0]   sboxModel [256];
    logic [7:0]   rconTable [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    aes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .round_sel (round_sel),
        .round_key (round_key),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checksTotal++;
        if (observed === expected) checksPassed++;
        else $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIPS-197 writes keys with byte 0 leftmost; the DUT keeps byte 0 at [7:0].
    function automatic logic [127:0] fromFips(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = s[(15-i)*8 +: 8];
        return r;
    endfunction

    // Carry-less 8x8 product reduced by 0x11b, long-division style.
    function automatic logic [7:0] modelMul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (15'h11b << (k - 8));
        return p[7:0];
    endfunction

    // S-box table from brute-force inverse search and the bitwise affine rule.
    task automatic buildSbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (modelMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                     ^ inv[(i+7)%8] ^ c[i];
            sboxModel[x] = s;
        end
    endtask

    // Textbook 44-word expansion over byte arrays.
    task automatic buildModel(input logic [127:0] key);
        logic [7:0] w [44][4];
        logic [7:0] temp [4];
        logic [7:0] first;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4; b++) w[i][b] = key[(4*i + b)*8 +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int b = 0; b < 4; b++) temp[b] = w[i-1][b];
            if (i % 4 == 0) begin
                first = temp[0];
                temp[0] = temp[1];
                temp[1] = temp[2];
                temp[2] = temp[3];
                temp[3] = first;
                for (int b = 0; b < 4; b++) temp[b] = sboxModel[temp[b]];
                temp[0] = temp[0] ^ rconTable[i/4 - 1];
            end
            for (int b = 0; b < 4; b++) w[i][b] = w[i-4][b] ^ temp[b];
        end
        for (int r = 0; r < 11; r++)
            for (int j = 0; j < 4; j++)
                for (int b = 0; b < 4; b++)
                    modelKeys[r][(4*j + b)*8 +: 8] = w[4*r + j][b];
    endtask

    // Pulse start with a key and step through the 11-edge expansion,
    // optionally re-pulsing start with a different key at cycles 3 and 7.
    task automatic applyStimulus(input logic [127:0] key, input bit repulse, input string tag);
        start  = 1'b1;
        key_in = key;
        tick();
        start  = 1'b0;
        checkOutput($sformatf("%s busy/done E0", tag), {126'd0, busy, done}, 128'd2);
        for (int k = 1; k <= 10; k++) begin
            if (repulse && (k == 3 || k == 7)) begin
                start  = 1'b1;
                key_in = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            start = 1'b0;
            checkOutput($sformatf("%s busy/done E%0d", tag, k), {126'd0, busy, done},
                        (k == 10) ? 128'd1 : 128'd2);
        end
    endtask

    // Read back every round key and compare against the model.
    task automatic verifyKeys(input string tag);
        for (int r = 0; r <= 10; r++) begin
            round_sel = 4'(r);
            tick();
            checkOutput($sformatf("%s rk%0d", tag, r), round_key, modelKeys[r]);
        end
    endtask

    task automatic readRound(input int r);
        round_sel = 4'(r);
        tick();
    endtask

    // Main test sequence.
    initial begin
        logic [127:0] key;
        rst       = 1'b1;
        start     = 1'b0;
        key_in    = '0;
        round_sel = 4'd0;
        buildSbox();
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset busy", {127'd0, busy}, 128'd0);
        checkOutput("reset done", {127'd0, done}, 128'd0);
        checkOutput("reset round_key", round_key, 128'd0);
        tick();
        checkOutput("reset rk0 read", round_key, 128'd0);

        // FIPS-197 key, anchored against published round keys.
        key = fromFips(128'h2b7e151628aed2a6abf7158809cf4f3c);
        buildModel(key);
        applyStimulus(key, 1'b0, "fips");
        readRound(1);
        checkOutput("fips rk1 const", round_key, fromFips(128'ha0fafe1788542cb123a339392a6c7605));
        readRound(10);
        checkOutput("fips rk10 const", round_key, fromFips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        verifyKeys("fips");

        // Out-of-range selections read zero while the key file is full.
        readRound(11);
        checkOutput("sel11", round_key, 128'd0);
        readRound(15);
        checkOutput("sel15", round_key, 128'd0);

        // Restart from DONE with the all-zero key.
        buildModel(128'd0);
        applyStimulus(128'd0, 1'b0, "zero");
        readRound(0);
        checkOutput("zero rk0 new key", round_key, 128'd0);
        readRound(1);
        checkOutput("zero rk1 const", round_key, fromFips(128'h62636363626363636263636362636363));
        readRound(10);
        checkOutput("zero rk10 const", round_key, fromFips(128'hb4ef5bcb3e92e21123e951cf6f8f188e));
        verifyKeys("zero");

        // Start re-pulsed mid-expansion with other keys must be ignored.
        key = {$urandom, $urandom, $urandom, $urandom};
        buildModel(key);
        applyStimulus(key, 1'b1, "repulse");
        verifyKeys("repulse");

        // Reset together with start at cycle 5 aborts the expansion.
        key = {$urandom, $urandom, $urandom, $urandom};
        round_sel = 4'd0;
        start  = 1'b1;
        key_in = key;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("abort busy", {127'd0, busy}, 128'd0);
        checkOutput("abort done", {127'd0, done}, 128'd0);
        checkOutput("abort round_key", round_key, 128'd0);
        tick();
        checkOutput("abort rk0 cleared", round_key, 128'd0);
        checkOutput("abort stays idle", {126'd0, busy, done}, 128'd0);

        // Fresh expansions after the abort, including back-to-back restarts.
        for (int n = 0; n < 3; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            buildModel(key);
            applyStimulus(key, 1'b0, $sformatf("rand%0d", n));
            verifyKeys($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
